// File: rtl/slength_decoder.sv
// slength_decoder: serial fixed-Huffman DEFLATE length-code decoder (symbols 256..285 plus extra bits)
module slength_decoder #(
    parameter int OUT_LEN_W = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 bit_in,
    input  logic                 bit_valid_in,
    output logic                 bit_ready_out,
    output logic [OUT_LEN_W-1:0] match_length_out,
    output logic                 match_valid_out,
    input  logic                 out_ready_in,
    output logic                 eob_out,
    output logic                 error_out
);
    typedef enum logic [1:0] {CODE, EXTRA, OUT} state_t;
    state_t state, state_n;
    logic       started, acc, eob, eob_n, err_n;
    logic [6:0] code_sr, code_sr_n, v7;
    logic [3:0] code_cnt, code_cnt_n, cnt_s;
    logic [8:0] base, base_n, len, len_n, sym, sym_base;
    logic [2:0] eb, eb_n, ex_cnt, ex_cnt_n, sym_eb;
    logic [4:0] ex_val, ex_val_n, ex_new, idx;
    logic [7:0] sr_s;
    logic       at7, at8, is_eob, more, hit, bad;
    assign bit_ready_out    = started && state != OUT;
    assign match_valid_out  = state == OUT;
    assign match_length_out = OUT_LEN_W'(len);
    assign eob_out          = eob;
    assign acc    = bit_valid_in && bit_ready_out;
    assign sr_s   = {code_sr, bit_in};
    assign cnt_s  = code_cnt + 4'd1;
    assign v7     = sr_s[6:0];
    assign at7    = cnt_s == 4'd7;
    assign at8    = cnt_s == 4'd8;
    assign is_eob = at7 && v7 == 7'd0;
    assign more   = at7 && v7 >= 7'd96 && v7 <= 7'd99;
    assign hit    = at7 ? (v7 >= 7'd1 && v7 <= 7'd23) : (at8 && sr_s >= 8'd192 && sr_s <= 8'd197);
    assign bad    = (at7 || at8) && !hit && !is_eob && !more;
    assign sym    = at8 ? 9'd88 + {1'b0, sr_s} : 9'd256 + {2'b0, v7};
    // Symbols 265..284 come in groups of four sharing an extra-bit count; base = ((4+pos)<<eb)+3
    assign idx      = sym[4:0] - 5'd9;
    assign sym_eb   = (sym < 9'd265 || sym == 9'd285) ? 3'd0 : idx[4:2] + 3'd1;
    assign sym_base = sym < 9'd265 ? sym - 9'd254 :
                      sym == 9'd285 ? 9'd258 : ({7'd1, idx[1:0]} << sym_eb) + 9'd3;
    assign ex_new   = ex_val | ({4'd0, bit_in} << ex_cnt);
    always_comb begin
        state_n    = state;
        code_sr_n  = code_sr;
        code_cnt_n = code_cnt;
        base_n     = base;
        eb_n       = eb;
        ex_cnt_n   = ex_cnt;
        ex_val_n   = ex_val;
        len_n      = len;
        eob_n      = eob;
        err_n      = 1'b0;
        if (state == CODE && acc) begin
            code_sr_n  = sr_s[6:0];
            code_cnt_n = cnt_s;
            if (bad) begin
                code_sr_n  = '0;
                code_cnt_n = '0;
                err_n      = 1'b1;
            end else if (is_eob) begin
                state_n = OUT;
                eob_n   = 1'b1;
                len_n   = '0;
            end else if (hit) begin
                base_n   = sym_base;
                eb_n     = sym_eb;
                ex_cnt_n = '0;
                ex_val_n = '0;
                len_n    = sym_base;
                if (sym_eb == 3'd0) state_n = OUT;
                else state_n = EXTRA;
            end
        end else if (state == EXTRA && acc) begin
            ex_val_n = ex_new;
            ex_cnt_n = ex_cnt + 3'd1;
            if (ex_cnt + 3'd1 == eb) begin
                len_n   = base + {4'd0, ex_new};
                state_n = OUT;
            end
        end else if (state == OUT && out_ready_in) begin
            state_n    = CODE;
            eob_n      = 1'b0;
            code_sr_n  = '0;
            code_cnt_n = '0;
            ex_cnt_n   = '0;
            ex_val_n   = '0;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= CODE;
            started   <= 1'b0;
            code_sr   <= '0;
            code_cnt  <= '0;
            base      <= '0;
            eb        <= '0;
            ex_cnt    <= '0;
            ex_val    <= '0;
            len       <= '0;
            eob       <= 1'b0;
            error_out <= 1'b0;
        end else begin
            state     <= state_n;
            started   <= 1'b1;
            code_sr   <= code_sr_n;
            code_cnt  <= code_cnt_n;
            base      <= base_n;
            eb        <= eb_n;
            ex_cnt    <= ex_cnt_n;
            ex_val    <= ex_val_n;
            len       <= len_n;
            eob       <= eob_n;
            error_out <= err_n;
        end
    end
endmodule

// File: tb/tb_slength_decoder.sv
// tb_slength_decoder: scenario tasks plus randomized symbols checked against an RFC 1951 length table
module tb_slength_decoder;
    logic       clk = 1'b0, rst = 1'b1, bit_in = 1'b0, bit_valid_in = 1'b0, out_ready_in = 1'b1;
    logic       bit_ready_out, match_valid_out, eob_out, error_out;
    logic [8:0] match_length_out;
    int n_tests = 0, n_fail = 0;
    int base_tab [0:28] = '{3, 4, 5, 6, 7, 8, 9, 10, 11, 13, 15, 17, 19, 23, 27, 31,
                            35, 43, 51, 59, 67, 83, 99, 115, 131, 163, 195, 227, 258};
    int eb_tab [0:28] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2,
                          3, 3, 3, 3, 4, 4, 4, 4, 5, 5, 5, 5, 0};

    slength_decoder #(.OUT_LEN_W(9)) dut (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid_in(bit_valid_in),
        .bit_ready_out(bit_ready_out), .match_length_out(match_length_out),
        .match_valid_out(match_valid_out), .out_ready_in(out_ready_in),
        .eob_out(eob_out), .error_out(error_out));

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Called and returns at a negedge; the bit is accepted on the posedge in between.
    task automatic send_bit(input logic b, input bit gaps);
        int t = 0;
        if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
        bit_in = b;
        bit_valid_in = 1'b1;
        while (!bit_ready_out && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_bit: bit_ready_out stayed 0 for %0d cycles (required 1)", t);
        end
        @(negedge clk);
        bit_valid_in = 1'b0;
    endtask

    // RFC 1951 fixed code: 256..279 -> 7-bit 0..23, 280..287 -> 8-bit 192..199, MSB first; extra LSB first.
    task automatic send_sym(input int sym, input int extra, input bit gaps);
        int c, n;
        c = sym < 280 ? sym - 256 : sym - 280 + 192;
        n = sym < 280 ? 7 : 8;
        for (int i = n - 1; i >= 0; i--) send_bit(c[i], gaps);
        if (sym >= 257)
            for (int i = 0; i < eb_tab[sym-257]; i++) send_bit(extra[i], gaps);
    endtask

    task automatic test_reset;
        #1;
        n_tests++;
        if ({bit_ready_out, match_valid_out, eob_out, error_out} !== 4'b0 || match_length_out !== 9'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: rdy=%b vld=%b eob=%b err=%b len=%0d required all 0",
                     bit_ready_out, match_valid_out, eob_out, error_out, match_length_out);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        n_tests++;
        if (bit_ready_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %b required 0 before first clock", bit_ready_out);
        end
        @(negedge clk);
        n_tests++;
        if (bit_ready_out !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_first_clock_ready: got %b required 1", bit_ready_out);
        end
    endtask

    task automatic test_directed;
        int syms [0:4] = '{257, 265, 269, 281, 285};
        int exts [0:4] = '{0, 1, 3, 20, 0};
        int exps [0:4] = '{3, 12, 22, 151, 258};
        for (int k = 0; k < 5; k++) begin
            send_sym(syms[k], exts[k], 1'b0);
            n_tests++;
            if (match_valid_out !== 1'b1 || match_length_out !== 9'(exps[k]) || eob_out !== 1'b0) begin
                n_fail++;
                $display("FAIL directed_sym%0d: vld=%b len=%0d eob=%b required vld=1 len=%0d eob=0",
                         syms[k], match_valid_out, match_length_out, eob_out, exps[k]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_eob;
        repeat (7) send_bit(1'b0, 1'b0);
        n_tests++;
        if (match_valid_out !== 1'b1 || eob_out !== 1'b1 || match_length_out !== 9'd0) begin
            n_fail++;
            $display("FAIL eob: vld=%b eob=%b len=%0d required vld=1 eob=1 len=0",
                     match_valid_out, eob_out, match_length_out);
        end
        @(negedge clk);
        n_tests++;
        if (match_valid_out !== 1'b0 || eob_out !== 1'b0) begin
            n_fail++;
            $display("FAIL eob_clear: vld=%b eob=%b required 0 0", match_valid_out, eob_out);
        end
    endtask

    task automatic test_errors;
        logic [7:0] pat8 = 8'b11000110;
        logic [6:0] pat7 = 7'b0011000;
        for (int k = 0; k < 2; k++) begin
            if (k == 0) for (int i = 7; i >= 0; i--) send_bit(pat8[i], 1'b0);
            else for (int i = 6; i >= 0; i--) send_bit(pat7[i], 1'b0);
            n_tests++;
            if (error_out !== 1'b1 || match_valid_out !== 1'b0) begin
                n_fail++;
                $display("FAIL error%0d_pulse: err=%b vld=%b required err=1 vld=0", k, error_out, match_valid_out);
            end
            @(negedge clk);
            n_tests++;
            if (error_out !== 1'b0 || match_valid_out !== 1'b0) begin
                n_fail++;
                $display("FAIL error%0d_one_cycle: err=%b vld=%b required 0 0", k, error_out, match_valid_out);
            end
            send_sym(258, 0, 1'b0);
            n_tests++;
            if (match_valid_out !== 1'b1 || match_length_out !== 9'd4) begin
                n_fail++;
                $display("FAIL error%0d_resync: vld=%b len=%0d required vld=1 len=4", k, match_valid_out, match_length_out);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure;
        out_ready_in = 1'b0;
        send_sym(273, 0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            n_tests++;
            if (match_valid_out !== 1'b1 || match_length_out !== 9'd35 || bit_ready_out !== 1'b0) begin
                n_fail++;
                $display("FAIL backpressure_hold%0d: vld=%b len=%0d rdy=%b required 1 35 0",
                         c, match_valid_out, match_length_out, bit_ready_out);
            end
            @(negedge clk);
        end
        out_ready_in = 1'b1;
        @(negedge clk);
        n_tests++;
        if (match_valid_out !== 1'b0 || bit_ready_out !== 1'b1) begin
            n_fail++;
            $display("FAIL backpressure_release: vld=%b rdy=%b required 0 1", match_valid_out, bit_ready_out);
        end
        send_sym(277, 9, 1'b0);
        n_tests++;
        if (match_valid_out !== 1'b1 || match_length_out !== 9'd76) begin
            n_fail++;
            $display("FAIL backpressure_next: vld=%b len=%0d required 1 76", match_valid_out, match_length_out);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        send_sym(257, 0, 1'b0);
        n_tests++;
        if (match_valid_out !== 1'b1 || bit_ready_out !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_out: vld=%b rdy=%b required 1 0", match_valid_out, bit_ready_out);
        end
        @(negedge clk);
        n_tests++;
        if (bit_ready_out !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_idle_slot: rdy=%b required 1 after one idle slot", bit_ready_out);
        end
        send_sym(260, 0, 1'b0);
        n_tests++;
        if (match_valid_out !== 1'b1 || match_length_out !== 9'd6) begin
            n_fail++;
            $display("FAIL b2b_second: vld=%b len=%0d required 1 6", match_valid_out, match_length_out);
        end
        @(negedge clk);
    endtask

    task automatic test_random;
        int sym, eb, extra, exp_len;
        for (int k = 0; k < 40; k++) begin
            sym = $urandom_range(257, 285);
            eb = eb_tab[sym-257];
            extra = eb == 0 ? 0 : $urandom_range(0, (1 << eb) - 1);
            exp_len = base_tab[sym-257] + extra;
            send_sym(sym, extra, 1'b1);
            n_tests++;
            if (match_valid_out !== 1'b1 || match_length_out !== 9'(exp_len) || eob_out !== 1'b0 || error_out !== 1'b0) begin
                n_fail++;
                $display("FAIL random%0d sym=%0d extra=%0d: vld=%b len=%0d eob=%b err=%b required 1 %0d 0 0",
                         k, sym, extra, match_valid_out, match_length_out, eob_out, error_out, exp_len);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0] c281 = 8'b11000001;
        for (int i = 7; i >= 4; i--) send_bit(c281[i], 1'b0);
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if ({bit_ready_out, match_valid_out, eob_out, error_out} !== 4'b0 || match_length_out !== 9'd0) begin
            n_fail++;
            $display("FAIL reset_mid_async: rdy=%b vld=%b eob=%b err=%b len=%0d required all 0",
                     bit_ready_out, match_valid_out, eob_out, error_out, match_length_out);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send_sym(257, 0, 1'b0);
        n_tests++;
        if (match_valid_out !== 1'b1 || match_length_out !== 9'd3) begin
            n_fail++;
            $display("FAIL reset_mid_recover: vld=%b len=%0d required 1 3", match_valid_out, match_length_out);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_directed;
        test_eob;
        test_errors;
        test_backpressure;
        test_back_to_back;
        test_random;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/slength_decoder.md
Name: slength_decoder

Overview:
- Inverse of the static-length encoder in the GZIP path.
- Consumes a DEFLATE bitstream serially, one bit per cycle, in LSB-first stream order.
- Decodes a fixed-Huffman length code (RFC 1951 symbols 256..287, 7 or 8 bits) plus its extra bits, and returns the match length 3..258.
- Sits in the inflate/verification path after the block-header parser, ahead of the distance decoder.

Parameters:
- OUT_LEN_W, 9, width of match_length_out; must be at least 9.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- bit_in  input  1  next stream bit
- bit_valid_in  input  1  bit_in is valid this cycle
- bit_ready_out  output  1  decoder accepts bit_in this cycle
- match_length_out  output  OUT_LEN_W  decoded length, 3..258
- match_valid_out  output  1  match_length_out is valid; held until accepted
- out_ready_in  input  1  downstream accepts the current result
- eob_out  output  1  symbol 256 decoded; qualified by match_valid_out, with match_length_out=0
- error_out  output  1  one-cycle pulse on an illegal code

Behaviour:
- Reset (asynchronous, any state): state=CODE, all counters and shift registers cleared.
  - Outputs at reset: bit_ready_out=0, match_valid_out=0, eob_out=0, error_out=0, match_length_out=0.
  - bit_ready_out goes to 1 on the first clock after rst deasserts.
  - A partial symbol in flight when rst asserts is discarded.
- Bit acceptance: a bit is accepted on a rising edge when bit_valid_in && bit_ready_out.
  - bit_ready_out = 1 only in states CODE and EXTRA.
- State CODE:
  - Shift each accepted bit into the LSB of code_sr (8 bits). The first bit received is the Huffman MSB.
  - Increment code_cnt.
- Evaluation at code_cnt==7, value v = code_sr[6:0]:
  - v==0: symbol 256 (EOB). Go to OUT with eob_out=1, match_length_out=0.
  - 1..23: symbol 256+v.
  - 96..99: 8-bit code. Stay in CODE for one more bit.
  - any other v: raise error.
- Evaluation at code_cnt==8, value w = code_sr[7:0]:
  - 192..197: symbol 280+(w-192).
  - 198, 199: raise error.
- Symbol to {base, extra count}:
  - 257..264: base 3..10, 0 extra bits.
  - 265..268: bases 11/13/15/17, 1 extra bit.
  - 269..272: bases 19/23/27/31, 2 extra bits.
  - 273..276: bases 35/43/51/59, 3 extra bits.
  - 277..280: bases 67/83/99/115, 4 extra bits.
  - 281..284: bases 131/163/195/227, 5 extra bits.
  - 285: base 258, 0 extra bits.
- Transitions after a valid symbol:
  - 0 extra bits: go to OUT.
  - otherwise: go to EXTRA.
- State EXTRA:
  - Extra bits arrive LSB-first. Bit k of the extra value is the k-th accepted bit.
  - After the last extra bit: match_length_out = base + extra (9-bit unsigned, no overflow possible), then go to OUT.
- State OUT:
  - match_valid_out=1 starting the cycle after the edge that accepted the final bit (1-cycle latency).
  - match_length_out and eob_out are held stable until out_ready_in=1.
  - On the edge where match_valid_out && out_ready_in: clear match_valid_out and eob_out, reset counters, go to CODE. bit_ready_out=1 in the next cycle.
  - Back-to-back symbols: at most one idle bit slot between the last bit of one symbol and the first bit of the next.
- Error:
  - error_out pulses high for exactly one cycle, in the cycle after the offending bit was accepted.
  - Nothing is emitted on match_valid_out.
  - Decoder returns to CODE with counters cleared and resynchronises on the next bit.
- Bubbles: cycles with bit_valid_in=0 in CODE or EXTRA hold all state.

Test Plan:
- Length 3: bits 0,0,0,0,0,0,1 (code 257) -> match_valid_out one cycle after the 7th bit, match_length_out=3, eob_out=0.
- Length 12: code 265 bits 0,0,0,1,0,0,1, then extra bit 1 -> 12. Length 22: code 269 bits 0,0,0,1,1,0,1, then extra 1,1 -> 22.
- 8-bit codes:
  - Length 151: bits 1,1,0,0,0,0,0,1 (code 281), then extra 0,0,1,0,1 -> 151.
  - Length 258: bits 1,1,0,0,0,1,0,1 (code 285) -> 258 with no extra bits.
- EOB and errors:
  - Seven 0 bits -> eob_out=1 with match_valid_out=1, match_length_out=0.
  - Bits 1,1,0,0,0,1,1,0 (code 286) -> error_out pulse for 1 cycle, no match_valid_out.
  - Bits 0,0,1,1,0,0,0 -> error_out after the 7th bit.
- Backpressure/bubbles: hold out_ready_in=0 for 5 cycles after a length-35 result -> output stable, bit_ready_out=0; then out_ready_in=1 -> next symbol decodes correctly. Random bit_valid_in gaps do not change results.
- Reset mid-symbol: assert rst after 4 bits of code 281 -> all outputs 0 immediately (asynchronous). After release, a full length-3 sequence decodes to 3.
